boot_loader: RTL



---
 rtl/boot_loader_if.sv | 31 +++
 rtl/boot_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/boot_loader_if.sv
// Byte-stream intake and program-memory write bus of the boot loader.
// No latency of its own; pure wiring bundle.
// Byte source backpressure via rx_valid/rx_ready; memory side has no backpressure.
interface boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [15:0] mem_ad;
  logic [7:0]  mem_din;

  // Loader side: consumes bytes, drives the program memory write port.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_ad,
    output mem_din
  );

  // Environment side: byte source and program memory.
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_ad,
    input  mem_din
  );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: parses SYNC/addr/len/data/chk frames into program memory, then releases the CPU.
// Latency: each accepted data byte produces a one-cycle mem_we pulse on the following cycle.
// Backpressure: rx_ready is high only in frame-parsing states; bytes offered otherwise are not consumed.
module boot_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_mode,
  boot_loader_if.slave  bus,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          err
);

  typedef enum logic [3:0] {
    S_RESET_CHK,
    S_SYNC,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rx_ready;
  logic        accept;
  logic        tmo_active;
  logic [15:0] base;
  logic [15:0] len;
  logic [15:0] idx;
  logic [15:0] idx_inc;
  logic [7:0]  sum;
  logic [7:0]  sum_nxt;
  logic [23:0] tmo_cnt;
  logic        mem_we_q;
  logic [15:0] mem_ad_q;
  logic [7:0]  mem_din_q;

  assign idx_inc     = idx + 16'd1;
  assign sum_nxt     = sum + bus.rx_data;
  assign bus.rx_ready = rx_ready;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_ad   = mem_ad_q;
  assign bus.mem_din  = mem_din_q;

  // State register; reset always restarts at the boot-mode check.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RESET_CHK;
    else        state <= state_nxt;
  end

  // Next-state, ready and timeout qualification; an acceptance beats an expiring timeout.
  always_comb begin
    state_nxt  = state;
    rx_ready   = 1'b0;
    tmo_active = 1'b0;
    case (state)
      S_SYNC: rx_ready = 1'b1;
      S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: begin
        rx_ready   = 1'b1;
        tmo_active = 1'b1;
      end
      default: ;
    endcase
    accept = rx_ready && bus.rx_valid;
    case (state)
      S_RESET_CHK: state_nxt = boot_mode ? S_SYNC : S_RUN;
      S_SYNC:      if (accept && bus.rx_data == SYNC_BYTE) state_nxt = S_ADDR_LO;
      S_ADDR_LO:   if (accept) state_nxt = S_ADDR_HI;
      S_ADDR_HI:   if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO:    if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI:    if (accept) state_nxt = ({bus.rx_data, len[7:0]} == 16'd0) ? S_CHK : S_DATA;
      S_DATA:      if (accept && idx_inc == len) state_nxt = S_CHK;
      S_CHK:       if (accept) state_nxt = (sum_nxt == 8'd0) ? S_RUN : S_ERROR;
      default: ;
    endcase
    if (tmo_active && !accept && tmo_cnt == TIMEOUT_CYCLES - 24'd1) state_nxt = S_ERROR;
  end

  // Frame datapath: header capture, running checksum, write strobes and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base      <= 16'd0;
      len       <= 16'd0;
      idx       <= 16'd0;
      sum       <= 8'd0;
      tmo_cnt   <= 24'd0;
      mem_we_q  <= 1'b0;
      mem_ad_q  <= 16'd0;
      mem_din_q <= 8'd0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (accept || !tmo_active) tmo_cnt <= 24'd0;
      else                       tmo_cnt <= tmo_cnt + 24'd1;
      if (accept) begin
        case (state)
          S_SYNC:    if (bus.rx_data == SYNC_BYTE) sum <= 8'd0;
          S_ADDR_LO: begin base[7:0]  <= bus.rx_data; sum <= sum_nxt; end
          S_ADDR_HI: begin base[15:8] <= bus.rx_data; sum <= sum_nxt; end
          S_LEN_LO:  begin len[7:0]   <= bus.rx_data; sum <= sum_nxt; end
          S_LEN_HI:  begin
            len[15:8] <= bus.rx_data;
            sum       <= sum_nxt;
            idx       <= 16'd0;
          end
          S_DATA: begin
            mem_we_q  <= 1'b1;
            mem_ad_q  <= base + idx;
            mem_din_q <= bus.rx_data;
            idx       <= idx_inc;
            sum       <= sum_nxt;
          end
          default: ;
        endcase
      end
      cpu_rst_n <= (state == S_RUN);
      done      <= (state == S_RUN);
      err       <= err || (state_nxt == S_ERROR);
    end
  end

endmodule
